csr_access_unit: RTL and testbench
==================================

Name: csr_access_unit

Overview:
- Initiator side of the CSR register-bank interface.
- Accepts one decoded Zicsr instruction (CSRRW/CSRRS/CSRRC and the I variants) from the execute stage.
- Sequences the bank read strobe, then the write strobe with the correct modify mode, and returns the old CSR value for rd writeback.
- Flags illegal accesses: bad funct3, writes to read-only CSRs.

Parameters:
- XLEN, 32, CSR data width.
- ADDR_W, 12, CSR address width.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  unit idle, request accepted when valid&ready.
- i_funct3  in  3  Zicsr funct3.
- i_csr_addr  in  12  CSR address.
- i_rs1_data  in  XLEN  rs1 value.
- i_rs1_idx  in  5  rs1 index; also zimm for the I variants.
- i_rd_idx  in  5  destination index.
- o_resp_valid  out  1  result available.
- i_resp_ready  in  1  consumer takes result.
- o_resp_data  out  XLEN  old CSR value (0 when the read is suppressed).
- o_resp_rd_idx  out  5  echoed rd.
- o_resp_illegal  out  1  illegal instruction.
- o_csr_rd_en  out  1  bank read strobe.
- o_csr_rd_addr  out  12  bank read address.
- i_csr_rd_data  in  XLEN  bank read data (combinational from bank).
- o_csr_wr_en  out  1  bank write strobe.
- o_csr_wr_addr  out  12  bank write address.
- o_csr_wr_data  out  XLEN  bank write data.
- o_csr_or  out  1  bank set mode.
- o_csr_and  out  1  bank clear mode (data is the inverted mask).

Behaviour:
- FSM states: IDLE, READ, WRITE, RESP. Exactly one request in flight.
- IDLE:
  - o_req_ready=1.
  - On valid&ready, latch funct3, addr, operand, rd_idx. Operand = i_rs1_data when funct3[2]=0, else zero-extended i_rs1_idx.
  - Go to READ.
- READ:
  - o_csr_rd_en=1 unless the read is suppressed (CSRRW/CSRRWI with rd_idx=0).
  - o_csr_rd_addr = latched addr.
  - Capture i_csr_rd_data at the clock edge. Suppressed read captures 0.
  - Go to WRITE if a write is required and the access is legal, else RESP.
- Write required when:
  - funct3[1:0]=01: always.
  - funct3[1:0]=10/11: operand != 0 (rs1 index, or zimm, != 0).
- WRITE: o_csr_wr_en=1 for exactly one cycle, wr_addr = latched addr, then RESP.
  - Mode 01: wr_data=operand, or=0, and=0.
  - Mode 10: wr_data=operand, or=1, and=0.
  - Mode 11: wr_data=~operand, or=0, and=1.
- RESP:
  - o_resp_valid held until i_resp_ready, then IDLE.
  - Response fields are stable while valid.
- Illegal cases:
  - funct3 = 000 or 100.
  - Write required to addr[11:10]=2'b11 (read-only, includes F11-F14).
  - Illegal requests skip WRITE and complete with o_resp_illegal=1 and o_resp_data=0.
  - No bank strobe is issued for a bad funct3.
  - A read-only write violation still performs the READ cycle.
- Latency: accept edge to resp_valid is 2 cycles without a write, 3 with a write. Back-to-back issue is possible once the response is taken.
- All strobes and response fields are registered outputs.
- Reset (sampled at any state): state=IDLE, all strobes=0, o_resp_valid=0, o_resp_data=0, o_resp_illegal=0, o_req_ready=1 after the edge.
  - Reset in WRITE drops the write.
  - Reset in RESP discards the result.
- i_req_valid is ignored outside IDLE.
- or and and are never both 1.
- wr_en and rd_en are never asserted in the same cycle.

Optional Feature:
- Macro: CSR_ACCESS_PRIV_CHECK_EN.
- When defined:
  - Extra input i_priv[1:0].
  - Access with i_csr_addr[9:8] > i_priv is illegal: no read, no write, o_resp_illegal=1.
- When undefined:
  - Port absent; all accesses treated as machine mode.
  - Only funct3 and read-only checks apply.

Test Plan:
- CSRRW addr 0x340, rs1 data 0xDEADBEEF, rd=5, bank holds 0x12345678:
  - rd_en one cycle, then wr_en with data 0xDEADBEEF, or=0, and=0.
  - Response 0x12345678, rd 5, 3 cycles after accept.
- CSRRC addr 0x300, rs1 data 0x0000_0008:
  - Write issued with and=1, data 0xFFFF_FFF7.
  - CSRRSI zimm=0 issues no write, returns the old value at 2-cycle latency.
- CSRRW addr 0xF11, rs1=3:
  - rd_en asserted, no wr_en, o_resp_illegal=1, resp_data=0.
  - Same read-only address via CSRRS with rs1=0 is legal and returns the bank value.
- funct3=100:
  - No strobes at all, illegal=1.
  - Hold i_resp_ready=0 for 4 cycles: resp_valid and data stay stable, o_req_ready=0.
- Assert i_rst during the WRITE state:
  - wr_en=0 after that edge, resp_valid=0.
  - Bank value unchanged; the next request is accepted normally.
- With CSR_ACCESS_PRIV_CHECK_EN, i_priv=0, CSRRS addr 0x300:
  - No strobes, illegal=1.
  - i_priv=3 on the same request completes normally.

Source files
------------

// File: rtl/csr_access_unit.sv
// csr_access_unit: Zicsr initiator sequencing CSR bank read/write strobes (ports: i_clk/i_rst, req i_req_valid/o_req_ready/i_funct3/i_csr_addr/i_rs1_data/i_rs1_idx/i_rd_idx, resp o_resp_*, bank o_csr_*/i_csr_rd_data; optional i_priv under CSR_ACCESS_PRIV_CHECK_EN)
module csr_access_unit #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 12
) (
  input  logic              i_clk,
  input  logic              i_rst,
`ifdef CSR_ACCESS_PRIV_CHECK_EN
  input  logic [1:0]        i_priv,
`endif
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [2:0]        i_funct3,
  input  logic [ADDR_W-1:0] i_csr_addr,
  input  logic [XLEN-1:0]   i_rs1_data,
  input  logic [4:0]        i_rs1_idx,
  input  logic [4:0]        i_rd_idx,
  output logic              o_resp_valid,
  input  logic              i_resp_ready,
  output logic [XLEN-1:0]   o_resp_data,
  output logic [4:0]        o_resp_rd_idx,
  output logic              o_resp_illegal,
  output logic              o_csr_rd_en,
  output logic [ADDR_W-1:0] o_csr_rd_addr,
  input  logic [XLEN-1:0]   i_csr_rd_data,
  output logic              o_csr_wr_en,
  output logic [ADDR_W-1:0] o_csr_wr_addr,
  output logic [XLEN-1:0]   o_csr_wr_data,
  output logic              o_csr_or,
  output logic              o_csr_and
);
  localparam logic [1:0] IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, RESP = 2'd3;
  logic [1:0]        state_q, state_d, mode_q, mode_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   op_q, op_d, wr_data_q, wr_data_d, resp_data_q, resp_data_d;
  logic [4:0]        rd_idx_q, rd_idx_d;
  logic              req_ready_q, req_ready_d, wr_go_q, wr_go_d, ill_q, ill_d;
  logic              rd_en_q, rd_en_d, wr_en_q, wr_en_d, wr_or_q, wr_or_d, wr_and_q, wr_and_d;
  logic              resp_valid_q, resp_valid_d, resp_ill_q, resp_ill_d;
  logic              bad_f3, wr_need, ro_viol, priv_viol, supp;
  assign bad_f3  = i_funct3[1:0] == 2'b00;
  // set/clear only write when the rs1 index (or zimm) is nonzero, not the rs1 value
  assign wr_need = i_funct3[1:0] == 2'b01 || i_rs1_idx != 5'd0;
  assign ro_viol = wr_need && i_csr_addr[11:10] == 2'b11;
`ifdef CSR_ACCESS_PRIV_CHECK_EN
  assign priv_viol = i_csr_addr[9:8] > i_priv;
`else
  assign priv_viol = 1'b0;
`endif
  assign supp = i_funct3[1:0] == 2'b01 && i_rd_idx == 5'd0;
  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    mode_d       = mode_q;
    addr_d       = addr_q;
    op_d         = op_q;
    rd_idx_d     = rd_idx_q;
    wr_go_d      = wr_go_q;
    ill_d        = ill_q;
    wr_data_d    = wr_data_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_ill_d   = resp_ill_q;
    rd_en_d      = 1'b0;
    wr_en_d      = 1'b0;
    wr_or_d      = 1'b0;
    wr_and_d     = 1'b0;
    case (state_q)
      IDLE: if (i_req_valid) begin
        state_d     = READ;
        req_ready_d = 1'b0;
        mode_d      = i_funct3[1:0];
        addr_d      = i_csr_addr;
        op_d        = i_funct3[2] ? {{(XLEN-5){1'b0}}, i_rs1_idx} : i_rs1_data;
        rd_idx_d    = i_rd_idx;
        ill_d       = bad_f3 || ro_viol || priv_viol;
        wr_go_d     = wr_need && !(bad_f3 || ro_viol || priv_viol);
        // a read-only violation still reads; bad funct3 and privilege faults do not
        rd_en_d     = !bad_f3 && !priv_viol && !supp;
      end
      READ: begin
        state_d      = wr_go_q ? WRITE : RESP;
        resp_data_d  = (rd_en_q && !ill_q) ? i_csr_rd_data : '0;
        wr_en_d      = wr_go_q;
        wr_or_d      = wr_go_q && mode_q == 2'b10;
        wr_and_d     = wr_go_q && mode_q == 2'b11;
        wr_data_d    = mode_q == 2'b11 ? ~op_q : op_q;
        resp_valid_d = !wr_go_q;
        resp_ill_d   = ill_q;
      end
      WRITE: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
      end
      default: if (i_resp_ready) begin
        state_d      = IDLE;
        resp_valid_d = 1'b0;
        req_ready_d  = 1'b1;
      end
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_or_q      <= 1'b0;
      wr_and_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_ill_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      rd_en_q      <= rd_en_d;
      wr_en_q      <= wr_en_d;
      wr_or_q      <= wr_or_d;
      wr_and_q     <= wr_and_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_ill_q   <= resp_ill_d;
    end
  end
  always_ff @(posedge i_clk) begin
    mode_q    <= mode_d;
    addr_q    <= addr_d;
    op_q      <= op_d;
    rd_idx_q  <= rd_idx_d;
    wr_go_q   <= wr_go_d;
    ill_q     <= ill_d;
    wr_data_q <= wr_data_d;
  end
  assign o_req_ready    = req_ready_q;
  assign o_resp_valid   = resp_valid_q;
  assign o_resp_data    = resp_data_q;
  assign o_resp_rd_idx  = rd_idx_q;
  assign o_resp_illegal = resp_ill_q;
  assign o_csr_rd_en    = rd_en_q;
  assign o_csr_rd_addr  = addr_q;
  // the bank commits on the edge that ends WRITE, so a reset landing on that edge must mask the strobe
  assign o_csr_wr_en    = wr_en_q && !i_rst;
  assign o_csr_wr_addr  = addr_q;
  assign o_csr_wr_data  = wr_data_q;
  assign o_csr_or       = wr_or_q;
  assign o_csr_and      = wr_and_q;
endmodule

// File: tb/tb_csr_access_unit.sv
// tb_csr_access_unit: randomized bench for csr_access_unit against a spec-level model with an emulated CSR bank
module tb_csr_access_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b1;
`ifdef CSR_ACCESS_PRIV_CHECK_EN
  logic [1:0]  i_priv = 2'd3;
`endif
  logic        i_req_valid = 1'b0, i_resp_ready = 1'b0;
  logic [2:0]  i_funct3 = '0;
  logic [11:0] i_csr_addr = '0;
  logic [31:0] i_rs1_data = '0;
  logic [4:0]  i_rs1_idx = '0, i_rd_idx = '0;
  logic        o_req_ready, o_resp_valid, o_resp_illegal, o_csr_rd_en, o_csr_wr_en, o_csr_or, o_csr_and;
  logic [31:0] o_resp_data, o_csr_wr_data, i_csr_rd_data;
  logic [4:0]  o_resp_rd_idx;
  logic [11:0] o_csr_rd_addr, o_csr_wr_addr;
  logic [31:0] bank [4096];
  logic [31:0] ref_bank [4096];
  logic [31:0] last_wr_data = '0;
  logic [11:0] last_rd_addr = '0;
  logic        last_or = 1'b0, last_and = 1'b0;
  int          rd_tot = 0, wr_tot = 0, viol_tot = 0;
  int          n_tests = 0, n_fail = 0;

  csr_access_unit dut (
    .i_clk(clk), .i_rst(rst),
`ifdef CSR_ACCESS_PRIV_CHECK_EN
    .i_priv(i_priv),
`endif
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_funct3(i_funct3),
    .i_csr_addr(i_csr_addr), .i_rs1_data(i_rs1_data), .i_rs1_idx(i_rs1_idx), .i_rd_idx(i_rd_idx),
    .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready), .o_resp_data(o_resp_data),
    .o_resp_rd_idx(o_resp_rd_idx), .o_resp_illegal(o_resp_illegal),
    .o_csr_rd_en(o_csr_rd_en), .o_csr_rd_addr(o_csr_rd_addr), .i_csr_rd_data(i_csr_rd_data),
    .o_csr_wr_en(o_csr_wr_en), .o_csr_wr_addr(o_csr_wr_addr), .o_csr_wr_data(o_csr_wr_data),
    .o_csr_or(o_csr_or), .o_csr_and(o_csr_and)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] bank_init(input int i);
    return 32'hA5A5_0000 | 32'(i);
  endfunction

  assign i_csr_rd_data = bank[o_csr_rd_addr];

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 4096; i++) bank[i] <= bank_init(i);
    end else if (o_csr_wr_en) begin
      bank[o_csr_wr_addr] <= o_csr_or ? (bank[o_csr_wr_addr] | o_csr_wr_data) :
                             o_csr_and ? (bank[o_csr_wr_addr] & o_csr_wr_data) : o_csr_wr_data;
    end
    if (o_csr_rd_en) begin
      rd_tot <= rd_tot + 1;
      last_rd_addr <= o_csr_rd_addr;
    end
    if (o_csr_wr_en) begin
      wr_tot <= wr_tot + 1;
      last_wr_data <= o_csr_wr_data;
      last_or <= o_csr_or;
      last_and <= o_csr_and;
    end
    if ((o_csr_rd_en && o_csr_wr_en) || (o_csr_or && o_csr_and)) viol_tot <= viol_tot + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_txn(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] d,
                        input logic [4:0] rs, input logic [4:0] rd, input int hold);
    logic [31:0] old, op, exp_data, exp_new;
    logic bad, need, ill, supp, pv, exp_wr, exp_rd;
    int cyc, rd0, wr0, v0;
    old = ref_bank[a];
    op = f3[2] ? {27'd0, rs} : d;
    bad = f3[1:0] == 2'b00;
    need = f3[1:0] == 2'b01 || rs != 5'd0;
    pv = 1'b0;
`ifdef CSR_ACCESS_PRIV_CHECK_EN
    pv = a[9:8] > i_priv;
`endif
    ill = bad || (need && a[11:10] == 2'b11) || pv;
    supp = f3[1:0] == 2'b01 && rd == 5'd0;
    exp_data = (ill || supp) ? 32'd0 : old;
    exp_rd = !(bad || pv || supp);
    exp_wr = need && !ill;
    exp_new = !exp_wr ? old : f3[1:0] == 2'b01 ? op : f3[1:0] == 2'b10 ? (old | op) : (old & ~op);
    ref_bank[a] = exp_new;
    check("req_ready_idle", 32'(o_req_ready), 32'd1);
    rd0 = rd_tot; wr0 = wr_tot; v0 = viol_tot;
    i_req_valid = 1'b1; i_funct3 = f3; i_csr_addr = a; i_rs1_data = d; i_rs1_idx = rs; i_rd_idx = rd;
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    cyc = 1;
    while (!o_resp_valid && cyc < 8) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", 32'(cyc), exp_wr ? 32'd3 : 32'd2);
    check("resp_data", o_resp_data, exp_data);
    check("resp_rd_idx", 32'(o_resp_rd_idx), 32'(rd));
    check("resp_illegal", 32'(o_resp_illegal), 32'(ill));
    check("req_ready_busy", 32'(o_req_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(o_resp_valid), 32'd1);
      check("hold_data", o_resp_data, exp_data);
      check("hold_illegal", 32'(o_resp_illegal), 32'(ill));
      check("hold_ready", 32'(o_req_ready), 32'd0);
    end
    i_resp_ready = 1'b1;
    @(posedge clk); #1;
    i_resp_ready = 1'b0;
    check("resp_done", 32'(o_resp_valid), 32'd0);
    check("rd_strobes", 32'(rd_tot - rd0), 32'(exp_rd));
    check("wr_strobes", 32'(wr_tot - wr0), 32'(exp_wr));
    check("strobe_overlap", 32'(viol_tot - v0), 32'd0);
    check("bank_value", bank[a], exp_new);
    if (exp_rd) check("rd_addr", 32'(last_rd_addr), 32'(a));
    if (exp_wr) begin
      check("wr_data", last_wr_data, f3[1:0] == 2'b11 ? ~op : op);
      check("wr_or", 32'(last_or), 32'(f3[1:0] == 2'b10));
      check("wr_and", 32'(last_and), 32'(f3[1:0] == 2'b11));
    end
  endtask

  initial begin
    int wr0;
    logic [11:0] addrs [5];
    addrs[0] = 12'h300; addrs[1] = 12'h340; addrs[2] = 12'hF11; addrs[3] = 12'hC01; addrs[4] = 12'h7C0;
    for (int i = 0; i < 4096; i++) ref_bank[i] = bank_init(i);
    repeat (3) @(posedge clk);
    #1;
    clr = 1'b0;
    rst = 1'b0;
    check("rst_req_ready", 32'(o_req_ready), 32'd1);
    check("rst_resp_valid", 32'(o_resp_valid), 32'd0);
    check("rst_rd_en", 32'(o_csr_rd_en), 32'd0);
    check("rst_wr_en", 32'(o_csr_wr_en), 32'd0);
    check("rst_resp_data", o_resp_data, 32'd0);
    check("rst_illegal", 32'(o_resp_illegal), 32'd0);
    do_txn(3'b001, 12'h340, 32'h1234_5678, 5'd1, 5'd0, 0);
    do_txn(3'b001, 12'h340, 32'hDEAD_BEEF, 5'd7, 5'd5, 0);
    do_txn(3'b011, 12'h300, 32'h0000_0008, 5'd2, 5'd4, 1);
    do_txn(3'b110, 12'h300, 32'h0, 5'd0, 5'd6, 0);
    do_txn(3'b001, 12'hF11, 32'h1, 5'd3, 5'd8, 0);
    do_txn(3'b010, 12'hF11, 32'hFFFF_FFFF, 5'd0, 5'd9, 0);
    do_txn(3'b100, 12'h300, 32'h5, 5'd5, 5'd10, 4);
    do_txn(3'b000, 12'h340, 32'h5, 5'd5, 5'd11, 0);
    // reset landing on the edge that ends WRITE must drop the write
    wr0 = wr_tot;
    i_req_valid = 1'b1; i_funct3 = 3'b001; i_csr_addr = 12'h305; i_rs1_data = 32'h55; i_rs1_idx = 5'd1; i_rd_idx = 5'd2;
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    @(posedge clk); #1;
    check("in_write", 32'(o_csr_wr_en), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstw_wr_en", 32'(o_csr_wr_en), 32'd0);
    check("rstw_valid", 32'(o_resp_valid), 32'd0);
    check("rstw_ready", 32'(o_req_ready), 32'd1);
    check("rstw_wr_cnt", 32'(wr_tot - wr0), 32'd0);
    check("rstw_bank", bank[12'h305], ref_bank[12'h305]);
    do_txn(3'b001, 12'h305, 32'h66, 5'd1, 5'd2, 0);
`ifdef CSR_ACCESS_PRIV_CHECK_EN
    i_priv = 2'd0;
    do_txn(3'b010, 12'h300, 32'h1, 5'd1, 5'd3, 0);
    i_priv = 2'd3;
    do_txn(3'b010, 12'h300, 32'h1, 5'd1, 5'd3, 0);
`endif
    for (int t = 0; t < 150; t++) begin
      logic [11:0] a;
      logic [4:0] rs, rd;
      a = $urandom_range(0, 5) == 5 ? 12'($urandom) : addrs[$urandom_range(0, 4)];
      rs = $urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom);
      rd = $urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom);
`ifdef CSR_ACCESS_PRIV_CHECK_EN
      i_priv = 2'($urandom);
`endif
      do_txn(3'($urandom), a, $urandom, rs, rd, int'($urandom_range(0, 2)));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
